// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state type, request encodings and word geometry for mem_ctrl.
// Revision 1.0
`default_nettype none

package mem_ctrl_pkg;

   localparam int BYTES_PER_WORD = 4;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_RWAIT = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/word_assembler.sv
// word_assembler: four byte lanes written by index; word shows the lane being written this cycle.
// Revision 1.0
`default_nettype none

module word_assembler
   import mem_ctrl_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [1:0]                  lane_sel,
   input  logic [7:0]                  din,
   output logic [8*BYTES_PER_WORD-1:0] word
);

   for (genvar i = 0; i < BYTES_PER_WORD; i++) begin : g_lane
      logic       hit;
      logic [7:0] lane_q;

      assign hit = wr_en && (lane_sel == 2'(i));

      always_ff @(posedge clk) begin
         if (rst)
            lane_q <= 8'h00;
         else if (hit)
            lane_q <= din;
      end

      // Bypass lets the final byte land in the completed word on the same edge.
      assign word[8*i +: 8] = hit ? din : lane_q;
   end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves core word read/write requests as four byte accesses on a byte-wide sync RAM.
// Revision 1.0
`default_nettype none

module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int LEN        = 32,
   parameter int ADDR_WIDTH = 17
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [1:0]            mem_vis_stage_state,
   input  logic [LEN-1:0]        write_data,
   output logic [LEN-1:0]        mem_data,
   output logic                  rdy_out,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_din,
   input  logic [7:0]            ram_dout,
   output logic                  ram_wr
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] base;
   logic [LEN-1:0]        wdata;
   logic [1:0]            cnt;
   logic [1:0]            cnt_next;
   logic                  req_valid;
   logic                  asm_wr;
   logic [1:0]            asm_lane;
   logic [LEN-1:0]        asm_word;

   assign cnt_next  = cnt + 2'd1;
   assign req_valid = (mem_vis_stage_state == MEM_READ) || (mem_vis_stage_state == MEM_WRITE);
   assign rdy_out   = (state == ST_DONE) || ((state == ST_IDLE) && !req_valid);

   // RAM data lags the address by one cycle, so lane cnt-1 is captured during READ.
   assign asm_wr   = ((state == ST_READ) && (cnt != 2'd0)) || (state == ST_RWAIT);
   assign asm_lane = (state == ST_RWAIT) ? 2'd3 : (cnt - 2'd1);

   word_assembler u_asm (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (asm_wr),
      .lane_sel (asm_lane),
      .din      (ram_dout),
      .word     (asm_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mem_data <= '0;
         ram_addr <= '0;
         ram_din  <= 8'h00;
         ram_wr   <= 1'b0;
         cnt      <= 2'd0;
         base     <= '0;
         wdata    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  base     <= mem_addr;
                  wdata    <= write_data;
                  cnt      <= 2'd0;
                  ram_addr <= mem_addr;
                  ram_din  <= write_data[7:0];
                  if (mem_vis_stage_state == MEM_WRITE) begin
                     ram_wr <= 1'b1;
                     state  <= ST_WRITE;
                  end else begin
                     state  <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (cnt == 2'd3) begin
                  state <= ST_RWAIT;
               end else begin
                  cnt      <= cnt_next;
                  ram_addr <= base + ADDR_WIDTH'(cnt_next);
               end
            end
            ST_RWAIT: begin
               mem_data <= asm_word;
               state    <= ST_DONE;
            end
            ST_WRITE: begin
               if (cnt == 2'd3) begin
                  ram_wr <= 1'b0;
                  state  <= ST_DONE;
               end else begin
                  cnt      <= cnt_next;
                  ram_addr <= base + ADDR_WIDTH'(cnt_next);
                  ram_din  <= wdata[{cnt_next, 3'b000} +: 8];
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a cycle-level behavioural model and literal spot checks.
// Revision 1.0
`default_nettype none

module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] mem_addr;
   logic [1:0]    req;
   logic [31:0]   write_data;
   logic [31:0]   mem_data;
   logic          rdy_out;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic [7:0]    ram_dout;
   logic          ram_wr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ram       [0:(1<<AW)-1];
   logic [7:0] model_mem [0:(1<<AW)-1];

   always #5 clk = ~clk;

   mem_ctrl #(.LEN(32), .ADDR_WIDTH(AW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .mem_addr            (mem_addr),
      .mem_vis_stage_state (req),
      .write_data          (write_data),
      .mem_data            (mem_data),
      .rdy_out             (rdy_out),
      .ram_addr            (ram_addr),
      .ram_din             (ram_din),
      .ram_dout            (ram_dout),
      .ram_wr              (ram_wr)
   );

   always @(posedge clk) begin
      if (ram_wr) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a transaction accepted in cycle t has fixed per-offset effects.
   int            edges   = 0;
   logic          rst_seen = 1'b0;
   always @(posedge clk) begin
      edges    <= edges + 1;
      rst_seen <= rst;
   end

   logic          m_active = 1'b0;
   logic          m_write  = 1'b0;
   int            m_k      = 0;
   logic [AW-1:0] m_base   = '0;
   logic [31:0]   m_wdata  = '0;
   logic [31:0]   m_md     = '0;

   always @(negedge clk) begin
      logic          e_rdy;
      logic          e_wr;
      logic [AW-1:0] a;
      if (edges != 0) begin
         if (rst_seen) begin
            m_active = 1'b0;
            m_md     = '0;
         end else if (m_active) begin
            m_k++;
         end
         e_wr = 1'b0;
         if (m_active) begin
            e_rdy = 1'b0;
            a     = m_base + AW'(m_k - 1);
            if (m_write) begin
               if (m_k >= 1 && m_k <= 4) begin
                  e_wr = 1'b1;
                  chk("wr_addr", 32'(ram_addr), 32'(a));
                  chk("wr_din", 32'(ram_din), 32'(m_wdata[8*(m_k-1) +: 8]));
                  model_mem[a] = m_wdata[8*(m_k-1) +: 8];
               end else if (m_k == 5) begin
                  e_rdy    = 1'b1;
                  m_active = 1'b0;
               end
            end else begin
               if (m_k >= 1 && m_k <= 4) begin
                  chk("rd_addr", 32'(ram_addr), 32'(a));
               end else if (m_k == 6) begin
                  m_md = {model_mem[m_base + AW'(3)], model_mem[m_base + AW'(2)],
                          model_mem[m_base + AW'(1)], model_mem[m_base]};
                  e_rdy    = 1'b1;
                  m_active = 1'b0;
               end
            end
         end else begin
            e_rdy = !((req == MEM_READ) || (req == MEM_WRITE));
            if (!e_rdy && !rst) begin
               m_active = 1'b1;
               m_write  = (req == MEM_WRITE);
               m_k      = 0;
               m_base   = mem_addr;
               m_wdata  = write_data;
            end
         end
         chk("rdy_out", 32'(rdy_out), 32'(e_rdy));
         chk("ram_wr", 32'(ram_wr), 32'(e_wr));
         chk("mem_data", mem_data, m_md);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single cycle, then wait for DONE; leaves the bench in DONE.
   task automatic issue(input logic [1:0] kind, input logic [AW-1:0] a, input logic [31:0] d,
                        output int lat);
      req = kind; mem_addr = a; write_data = d;
      lat = 0;
      cyc();
      req = MEM_NONE;
      lat = 1;
      while (!rdy_out && lat < 20) begin
         cyc();
         lat++;
      end
      if (!rdy_out) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: no DONE after %0d cycles, required 6 or fewer", lat);
      end
   endtask

   initial begin
      int lat;
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = 8'h00;
         model_mem[i] = 8'h00;
      end
      ram[17'h00100] = 8'h78; ram[17'h00101] = 8'h56; ram[17'h00102] = 8'h34; ram[17'h00103] = 8'h12;
      ram[17'h1FFFE] = 8'hAA; ram[17'h1FFFF] = 8'hBB; ram[17'h00000] = 8'hCC; ram[17'h00001] = 8'hDD;
      for (int i = 0; i < 4; i++) begin
         model_mem[17'h00100 + i] = ram[17'h00100 + i];
         model_mem[17'h1FFFE + i] = ram[17'h1FFFE + i];
         model_mem[i]             = ram[i];
      end

      rst = 1'b1; req = MEM_NONE; mem_addr = '0; write_data = '0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      chk("reset_mem_data", mem_data, 32'h0);
      chk("reset_ram_wr", 32'(ram_wr), 32'h0);
      chk("reset_rdy", 32'(rdy_out), 32'h1);
      cyc();

      issue(MEM_READ, 17'h00100, 32'h0, lat);
      chk("read_latency", 32'(lat), 32'd6);
      chk("read_word", mem_data, 32'h12345678);
      cyc();

      issue(MEM_WRITE, 17'h00200, 32'hDEADBEEF, lat);
      chk("write_latency", 32'(lat), 32'd5);
      cyc();
      chk("write_bytes", {ram[17'h00203], ram[17'h00202], ram[17'h00201], ram[17'h00200]}, 32'hDEADBEEF);
      chk("mem_data_held", mem_data, 32'h12345678);

      issue(MEM_READ, 17'h00200, 32'h0, lat);
      chk("readback_word", mem_data, 32'hDEADBEEF);
      cyc();

      issue(MEM_READ, 17'h1FFFE, 32'h0, lat);
      chk("wrap_word", mem_data, 32'hDDCCBBAA);
      cyc();

      // Request inputs switch to a write mid-read and must be ignored until the next IDLE.
      req = MEM_READ; mem_addr = 17'h00100;
      cyc(); cyc();
      req = MEM_WRITE; mem_addr = 17'h00300; write_data = 32'h11223344;
      repeat (4) cyc();
      chk("midop_done", 32'(rdy_out), 32'h1);
      chk("midop_word", mem_data, 32'h12345678);
      req = MEM_NONE;
      cyc();
      chk("midop_no_write", {ram[17'h00303], ram[17'h00302], ram[17'h00301], ram[17'h00300]}, 32'h0);

      // Reset sampled at the edge that opens t+3 of a write: bytes 0 and 1 land, the rest do not.
      req = MEM_WRITE; mem_addr = 17'h00400; write_data = 32'hCAFEF00D;
      cyc();
      req = MEM_NONE;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_mid_ram_wr", 32'(ram_wr), 32'h0);
      chk("rst_mid_mem_data", mem_data, 32'h0);
      chk("rst_mid_rdy", 32'(rdy_out), 32'h1);
      cyc(); cyc();
      chk("rst_mid_bytes", {ram[17'h00403], ram[17'h00402], ram[17'h00401], ram[17'h00400]}, 32'h0000F00D);

      // Held read request: DONE ignores it, the following IDLE starts the next read (7-cycle spacing).
      req = MEM_READ; mem_addr = 17'h00100;
      repeat (6) cyc();
      chk("b2b_first_done", 32'(rdy_out), 32'h1);
      cyc();
      chk("b2b_second_start", 32'(rdy_out), 32'h0);
      repeat (6) cyc();
      chk("b2b_second_done", 32'(rdy_out), 32'h1);
      req = MEM_NONE;
      chk("b2b_word", mem_data, 32'h12345678);
      cyc(); cyc();

      for (int i = 0; i < 4; i++) begin
         chk("ram_vs_model_200", 32'(ram[17'h00200 + i]), 32'(model_mem[17'h00200 + i]));
         chk("ram_vs_model_400", 32'(ram[17'h00400 + i]), 32'(model_mem[17'h00400 + i]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
